mitch_trunc_div_w8_pipe: RTL and testbench
==========================================

Name: mitch_trunc_div_w8_pipe

Overview:
- Pipelined Mitchell-logarithm approximate divider. It is the inverse-direction companion of the team's truncated Mitchell multiplier.
- Log-encodes dividend and divisor with a mantissa truncated to W_MANT bits, subtracts the logs, then antilogs the result to a Q24.8 quotient.
- Three register stages with valid/ready handshake on both sides. Full backpressure; throughput 1 result/cycle.
- Sits in the approximate-arithmetic datapath beside the multiplier. Uses the same one's-complement sign convention.

Parameters:
- W_MANT, 7, mantissa fraction bits kept after the leading one (truncation width). Only the default is verified.
- FRAC_OUT, 8, fractional bits of the quotient output. Fixed; listed for the package.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- in_valid_i  in  1  operand pair valid.
- in_ready_o  out  1  pipeline can accept an operand pair this cycle.
- x_i  in  16  dividend, signed.
- y_i  in  16  divisor, signed.
- out_valid_o  out  1  quotient valid.
- out_ready_i  in  1  consumer accepts the quotient.
- q_o  out  32  quotient, Q24.8. Magnitude in [23:0]; negative results are one's complement (whole word XOR with sign).
- dz_o  out  1  divide-by-zero flag; qualified by out_valid_o.

Behaviour:
- Reset (async assert, sync release): stage valids v1, v2, v3 = 0; out_valid_o = 0; q_o = 0; dz_o = 0; all stage data registers = 0. Reset asserted mid-operation flushes all in-flight results; none are delivered.
- Clock and reset are fixed as stated: one clock; reset is asynchronous and active-low.
- Handshake:
  - ready3 = out_ready_i. readyk = !v(k+1) | ready(k+1). in_ready_o = !v1 | ready1.
  - Stage k loads when !vk | readyk. A transfer occurs when valid & ready on that boundary.
  - Latency: 3 cycles from input accept to out_valid_o with no stall.
  - While out_valid_o=1 and out_ready_i=0: q_o and dz_o hold stable and no stage data is lost or duplicated.
  - Bubbles collapse: a stalled output does not block earlier stages from filling empty slots.
- Stage 1 (encode):
  - xa = x ^ {16{x[15]}}, ya likewise. This one's-complement abs is a deliberate approximation: x = -1 gives xa = 0.
  - kx = index of the leading one of xa (0..15).
  - mx = the W_MANT bits directly below the leading one, zero-padded; the rest are truncated. Same for y.
  - Register: {kx,mx}, {ky,my}, sgn = x[15]^y[15], zx = (xa==0), zy = (ya==0).
- Stage 2 (subtract):
  - L = {1'b0,kx,mx} - {1'b0,ky,my}, 12-bit two's complement.
  - The characteristic c = L[11:7] is signed (-15..14); the fraction f = L[6:0]. Floor semantics automatically give the mx<my Mitchell case.
  - Propagate sgn, zx, zy.
- Stage 3 (antilog):
  - m = {1'b1,f} (value (1+f/128)*128).
  - If c >= -1: mag = m << (c+1). If c < -1: mag = m >> -(c+1). A right shift of 8 or more gives 0.
  - Maximum is 255<<15 = 0x7F8000, which fits in 24 bits.
  - Outputs:
    - zy = 1: dz_o = 1, q_o = 0. This takes priority over zx.
    - else zx = 1: dz_o = 0, q_o = 0.
    - otherwise: dz_o = 0, q_o = {32{sgn}} ^ {8'b0,mag}.
- Simultaneous input accept and output drain in the same cycle are both honoured.

Decomposition:
- Package mitch_div_pkg holds:
  - constants W_IN=16, W_MANT=7, W_K=4, W_L=12, FRAC_OUT=8;
  - packed struct typedefs for the stage-1 and stage-2 payloads (k/m pairs or L, sgn, zx, zy).
- One sub-module, mitch_log_encode: abs, leading-one detect, priority encode, normalize shift, truncate.
  - Built from the existing LOD16, PriorityEncoder_16 and Barrel16L library blocks.
  - Instantiated twice, for x and y.
- Top level holds the subtractor, antilog shifter, sign/zero mux and the handshake pipeline.

Test Plan:
- x=100, y=10, out_ready_i=1 -> after 3 cycles q_o=0x00000A80 (10.5), dz_o=0.
- x=10, y=100 -> q_o=0x0000001B (27/256). x=32767, y=1 -> q_o=0x007F8000.
- x=-101, y=10 -> q_o=0xFFFFF57F. x=0, y=7 -> q_o=0, dz_o=0. x=5, y=0 and x=0, y=-1 -> q_o=0, dz_o=1.
- Stream 8 back-to-back pairs with out_ready_i held 0 for cycles 4-9:
  - in_ready_o drops after 3 accepts;
  - out_valid_o/q_o stay stable during the stall;
  - all 8 results come out in order with no loss or duplicates;
  - back to 1 result/cycle after release.
- Random out_ready_i toggling over 10k random pairs -> every output matches a bit-exact reference model, in order.
- Assert rst_ni low mid-stream with 3 results in flight -> out_valid_o=0, q_o=0 immediately (async); after release the first output is the first pair accepted after reset.

Source files
------------

// File: rtl/mitch_div_pkg.sv
// Shared constants and stage payload types for the Mitchell approximate divider.
package mitch_div_pkg;
    localparam int W_IN     = 16;
    localparam int W_MANT   = 7;
    localparam int W_K      = 4;
    localparam int W_L      = 12;
    localparam int FRAC_OUT = 8;

    typedef struct packed {
        logic [W_K-1:0]    k;
        logic [W_MANT-1:0] m;
    } log_t;

    typedef struct packed {
        log_t lx;
        log_t ly;
        logic sgn;
        logic zx;
        logic zy;
    } s1_t;

    typedef struct packed {
        logic [W_L-1:0] l;
        logic           sgn;
        logic           zx;
        logic           zy;
    } s2_t;
endpackage

// File: rtl/mitch_log_encode.sv
// One's-complement abs, leading-one detect and normalize/truncate into a {k,m} log code.
module mitch_log_encode
    import mitch_div_pkg::*;
(
    input  logic [W_IN-1:0] v_i,
    output log_t            log_o,
    output logic            zero_o
);
    logic [W_IN-1:0] a;
    logic [W_K-1:0]  k;
    logic [W_IN-1:0] norm;

    assign a = v_i ^ {W_IN{v_i[W_IN-1]}};

    // NOTE: give every always_comb output a default first so no path leaves it unassigned (latch).
    always_comb begin
        k = '0;
        for (int i = 0; i < W_IN; i++) begin
            if (a[i]) k = W_K'(i);
        end
    end

    // Leading one lands on bit 15; the W_MANT bits beneath it are the mantissa.
    assign norm    = a << (W_K'(W_IN - 1) - k);
    assign log_o.k = k;
    assign log_o.m = norm[W_IN-2 -: W_MANT];
    assign zero_o  = (a == '0);
endmodule

// File: rtl/mitch_trunc_div_w8_pipe.sv
// Three-stage Mitchell-log approximate divider (encode, subtract, antilog) with elastic handshake.
module mitch_trunc_div_w8_pipe
    import mitch_div_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [W_IN-1:0] x_i,
    input  logic [W_IN-1:0] y_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [31:0]     q_o,
    output logic            dz_o
);
    logic        v1_q, v2_q, v3_q;
    s1_t         s1_q, s1_d;
    s2_t         s2_q, s2_d;
    logic [31:0] q_q, q_d;
    logic        dz_q, dz_d;
    logic        ready1, ready2, ready3;
    logic        zx, zy;

    assign ready3     = out_ready_i;
    assign ready2     = !v3_q || ready3;
    assign ready1     = !v2_q || ready2;
    assign in_ready_o = !v1_q || ready1;

    mitch_log_encode u_enc_x (.v_i(x_i), .log_o(s1_d.lx), .zero_o(zx));
    mitch_log_encode u_enc_y (.v_i(y_i), .log_o(s1_d.ly), .zero_o(zy));

    assign s1_d.sgn = x_i[W_IN-1] ^ y_i[W_IN-1];
    assign s1_d.zx  = zx;
    assign s1_d.zy  = zy;

    assign s2_d.l   = {1'b0, s1_q.lx} - {1'b0, s1_q.ly};
    assign s2_d.sgn = s1_q.sgn;
    assign s2_d.zx  = s1_q.zx;
    assign s2_d.zy  = s1_q.zy;

    logic signed [4:0] c;
    logic [7:0]        m;
    logic [23:0]       mag;

    assign c = s2_q.l[W_L-1:W_MANT];
    assign m = {1'b1, s2_q.l[W_MANT-1:0]};

    // For c < -1 the right-shift distance -(c+1) is simply ~c in five bits.
    always_comb begin
        mag = '0;
        if (c >= -5'sd1) mag = 24'(m) << 4'(c + 5'sd1);
        else             mag = 24'(m) >> (~c);
    end

    always_comb begin
        q_d  = '0;
        dz_d = 1'b0;
        if (s2_q.zy)      dz_d = 1'b1;
        else if (!s2_q.zx) q_d = {32{s2_q.sgn}} ^ {8'b0, mag};
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    // NOTE: data registers are reset too, so q_o reads 0 during and right after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            s1_q <= '0;
            s2_q <= '0;
            q_q  <= '0;
            dz_q <= 1'b0;
        end else begin
            if (in_ready_o) begin
                v1_q <= in_valid_i;
                s1_q <= s1_d;
            end
            if (ready1) begin
                v2_q <= v1_q;
                s2_q <= s2_d;
            end
            if (ready2) begin
                v3_q <= v2_q;
                q_q  <= q_d;
                dz_q <= dz_d;
            end
        end
    end

    assign out_valid_o = v3_q;
    assign q_o         = q_q;
    assign dz_o        = dz_q;
endmodule

// File: tb/tb_mitch_trunc_div_w8_pipe.sv
// Self-checking bench: directed vectors, stall, random backpressure and mid-stream reset.
module tb_mitch_trunc_div_w8_pipe;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [15:0] x_i = '0;
    logic [15:0] y_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] q_o;
    logic        dz_o;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    logic        exp_dz[$];
    logic        last_acc, last_pop;

    mitch_trunc_div_w8_pipe dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .x_i(x_i), .y_i(y_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .q_o(q_o), .dz_o(dz_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    // Reference divider from integer arithmetic: {dz, q}.
    function automatic logic [32:0] model(input logic [15:0] x, input logic [15:0] y);
        int sx, sy, xa, ya, kx, ky, mx, my, l, c, f, e, mag;
        logic [31:0] q;
        sx = int'($signed(x));
        sy = int'($signed(y));
        xa = (sx < 0) ? -sx - 1 : sx;
        ya = (sy < 0) ? -sy - 1 : sy;
        if (ya == 0) return {1'b1, 32'h0};
        if (xa == 0) return {1'b0, 32'h0};
        kx = 0; while ((xa >> (kx + 1)) != 0) kx++;
        ky = 0; while ((ya >> (ky + 1)) != 0) ky++;
        mx = ((xa * 128) >> kx) - 128;
        my = ((ya * 128) >> ky) - 128;
        l  = (kx * 128 + mx) - (ky * 128 + my);
        c  = (l >= 0) ? l / 128 : -((-l + 127) / 128);
        f  = l - c * 128;
        e  = c + 1;
        mag = (e >= 0) ? ((128 + f) << e) : ((128 + f) >> (-e));
        q = 32'(mag);
        if ((sx < 0) != (sy < 0)) q = ~q;
        return {1'b0, q};
    endfunction

    // Called at a negedge with inputs already driven; scores this cycle's transfers, advances one cycle.
    task automatic tick();
        logic [32:0] r;
        logic [31:0] eq;
        logic        ed;
        #1;
        last_acc = in_valid_i && in_ready_o;
        last_pop = out_valid_o && out_ready_i;
        if (last_acc) begin
            r = model(x_i, y_i);
            exp_q.push_back(r[31:0]);
            exp_dz.push_back(r[32]);
        end
        if (last_pop) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 32'(out_valid_o), 32'd0);
            end else begin
                eq = exp_q.pop_front();
                ed = exp_dz.pop_front();
                check("stream_q", q_o, eq);
                check("stream_dz", 32'(dz_o), 32'(ed));
            end
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic run_dir(input string tag, input logic [15:0] x, input logic [15:0] y,
                           input logic [31:0] eq, input logic edz);
        int lat;
        bit seen;
        logic [32:0] r;
        r = model(x, y);
        check({tag, "_model"}, r[31:0], eq);
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        x_i = x;
        y_i = y;
        tick();
        in_valid_i = 1'b0;
        check({tag, "_accept"}, 32'(last_acc), 32'd1);
        seen = 0;
        lat  = 0;
        for (int i = 1; i <= 10 && !seen; i++) begin
            #1;
            if (out_valid_o) begin
                seen = 1;
                lat  = i;
                check({tag, "_q"}, q_o, eq);
                check({tag, "_dz"}, 32'(dz_o), 32'(edz));
            end
            tick();
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'd3);
    endtask

    initial begin
        logic [15:0] sx[8], sy[8];
        logic [31:0] hold_q;
        int idx, acc, pops;

        repeat (2) @(negedge clk_i);
        #1;
        check("rst_out_valid", 32'(out_valid_o), 32'd0);
        check("rst_q", q_o, 32'd0);
        check("rst_dz", 32'(dz_o), 32'd0);
        check("rst_in_ready", 32'(in_ready_o), 32'd1);
        rst_ni = 1'b1;
        @(negedge clk_i);

        run_dir("d100_10",  16'd100,   16'd10,     32'h00000A80, 1'b0);
        run_dir("d10_100",  16'd10,    16'd100,    32'h0000001B, 1'b0);
        run_dir("dmax",     16'd32767, 16'd1,      32'h007F8000, 1'b0);
        run_dir("dneg",     -16'sd101, 16'd10,     32'hFFFFF57F, 1'b0);
        run_dir("dzx",      16'd0,     16'd7,      32'h00000000, 1'b0);
        run_dir("dzy",      16'd5,     16'd0,      32'h00000000, 1'b1);
        run_dir("dzboth",   16'd0,     16'hFFFF,   32'h00000000, 1'b1);

        // Stall: output blocked while streaming 8 pairs.
        for (int i = 0; i < 8; i++) begin
            sx[i] = 16'($urandom);
            sy[i] = 16'($urandom);
        end
        idx = 0; acc = 0;
        out_ready_i = 1'b0;
        for (int c = 0; c < 6; c++) begin
            in_valid_i = 1'b1;
            x_i = sx[idx];
            y_i = sy[idx];
            tick();
            if (last_acc) begin idx++; acc++; end
        end
        check("stall_accepts", 32'(acc), 32'd3);
        check("stall_in_ready", 32'(in_ready_o), 32'd0);
        #1;
        hold_q = q_o;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("stall_valid_hold", 32'(out_valid_o), 32'd1);
            check("stall_q_hold", q_o, hold_q);
        end
        out_ready_i = 1'b1;
        pops = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid_i = (idx < 8);
            x_i = sx[idx & 7];
            y_i = sy[idx & 7];
            tick();
            if (last_acc) idx++;
            if (last_pop) pops++;
        end
        in_valid_i = 1'b0;
        check("release_throughput", 32'(pops), 32'd8);
        for (int c = 0; c < 10 && exp_q.size() != 0; c++) tick();
        check("stall_drained", 32'(exp_q.size()), 32'd0);

        // Random traffic with random backpressure.
        idx = 0;
        for (int c = 0; c < 40000 && idx < 10000; c++) begin
            in_valid_i  = 1'($urandom_range(0, 3) != 0);
            out_ready_i = 1'($urandom_range(0, 2) != 0);
            x_i = 16'($urandom);
            y_i = 16'($urandom);
            if (($urandom & 15) == 0) y_i = 16'($urandom_range(0, 1)) - 16'd1 + 16'd1;
            tick();
            if (last_acc) idx++;
        end
        check("random_count", 32'(idx), 32'd10000);
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        for (int c = 0; c < 10 && exp_q.size() != 0; c++) tick();
        check("random_drained", 32'(exp_q.size()), 32'd0);

        // Mid-stream reset with three results in flight.
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            x_i = 16'd1000 + 16'(c);
            y_i = 16'd3;
            tick();
        end
        in_valid_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid_o), 32'd0);
        check("async_rst_q", q_o, 32'd0);
        exp_q.delete();
        exp_dz.delete();
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        run_dir("post_rst", 16'd100, 16'd10, 32'h00000A80, 1'b0);
        check("post_rst_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
